// File: rtl/sync_mod_counter.sv
// Up/down modulo-MODULUS counter with clear, clamped load, tc and wrap pulse.
// Define SYNC_MOD_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module sync_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_cfg
    $error("sync_mod_counter: need WIDTH>=1, 2<=MODULUS<=2**WIDTH");
  end

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_min;

  assign at_max = (q == MAX);
  assign at_min = (q == '0);
  assign tc     = en & ((up & at_max) | (~up & at_min));

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    priority case (1'b1)
      clr: q_nxt = '0;
      load: q_nxt = (load_val > MAX) ? MAX : load_val;
      en & up: begin
        if (at_max) begin
`ifdef SYNC_MOD_COUNTER_SATURATE_EN
          q_nxt = MAX;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end
      en & ~up: begin
        if (at_min) begin
`ifdef SYNC_MOD_COUNTER_SATURATE_EN
          q_nxt = '0;
`else
          q_nxt    = MAX;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule
